noc_inject_arbiter: RTL and testbench
=====================================

# noc_inject_arbiter

Packet-granular round-robin arbiter that shares one NoC local injection port among `N_SRC` flit sources, e.g. the management-application injector and the application injector. Each source drives the same tx/credit/data handshake as the port it feeds, plus an end-of-packet marker. The arbiter locks the port to one source for a whole packet, so flits of different packets never interleave. It sits between the injectors and the PE/router local input.

## Interface
- `FLIT_SIZE`, 32, flit width in bits.
- `N_SRC`, 2, number of requesting sources (2..8).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `tx_i`  in  N_SRC  per-source flit-valid.
- `eop_i`  in  N_SRC  per-source "this flit is the last of the packet", qualified by `tx_i`.
- `data_i`  in  N_SRC*FLIT_SIZE  per-source flit; source s occupies bits [s*FLIT_SIZE +: FLIT_SIZE].
- `credit_o`  out  N_SRC  per-source ready; at most one bit high at a time.
- `tx_o`  out  1  flit-valid toward the NoC port.
- `data_o`  out  FLIT_SIZE  flit toward the NoC port.
- `credit_i`  in  1  NoC port ready.
- `grant_o`  out  N_SRC  one-hot granted source; all zeros when idle.
- `flit_cnt_o`  out  16  flits transferred in the current or most recent packet.

## Operation
- A flit transfers on a rising edge where `tx_o && credit_i` is true.
- FSM has two states.
  - IDLE: `grant_o = 0`, `tx_o = 0`, `credit_o = 0`. If any `tx_i` bit is high, select the first requesting source at or after the round-robin pointer `rr_ptr`, searching upward and wrapping modulo `N_SRC`. Register the selection as `grant_o` and go to LOCKED. `flit_cnt_o` is cleared to 0 on that same edge.
  - LOCKED(g):
    - `tx_o = tx_i[g]`, `data_o = data_i[g]`, `credit_o[g] = credit_i`, all other `credit_o` bits 0. These are combinational pass-through paths.
    - Each transfer increments `flit_cnt_o`, which saturates at 0xFFFF.
    - A transfer with `eop_i[g]` high moves the FSM to IDLE and sets `rr_ptr = (g+1) mod N_SRC`.
- Requests from non-granted sources are ignored while LOCKED. They are not lost, because sources hold `tx_i` until credited.
- A packet of a single flit (`eop_i` high on the first flit) is legal: one cycle in LOCKED.
- `tx_i[g]` dropping mid-packet is a source bubble. The lock holds and no timeout applies.
- `eop_i` is ignored when `tx_i` is low or when no transfer occurs.
- `data_o` is 0 whenever `tx_o` is 0.

## Timing
- Reset values:
  - state IDLE, `rr_ptr = 0`, `grant_o = 0`, `flit_cnt_o = 0`.
  - `tx_o = 0`, `data_o = 0`, `credit_o = 0`.
- Reset asserted mid-packet abandons the packet immediately. Outputs go to reset values asynchronously; the NoC sees a truncated packet. That is acceptable because reset is system-wide.
- Arbitration latency: request seen in IDLE on edge k → grant visible after edge k → first transfer possible at edge k+1.
- Packet turnaround: the EOP transfer at edge k returns the FSM to IDLE. The next packet's first transfer is no earlier than edge k+2, one bubble cycle per packet.
- Throughput inside a packet: one flit per cycle while `tx_i[g]` and `credit_i` are both high.
- Simultaneous requests in IDLE: the lowest index at or after `rr_ptr` wins. Two always-requesting sources therefore alternate packet-by-packet.
- `rr_ptr` wraps from `N_SRC-1` to 0.

## Structure
- Shared package `inject_pkg`: `arb_state_t` (IDLE, LOCKED) and `FLIT_CNT_W = 16`.
- Sub-module `rr_select`: combinational. Takes the `N_SRC`-bit request vector and the pointer, and returns a one-hot grant. It is reusable by other NoC arbiters.
- The top holds the FSM, the `rr_ptr` and `grant_o` registers, the flit counter and the output muxes.

## Test plan
- Reset then single source: src0 sends 4 flits `0x10..0x13`, EOP on `0x13`, `credit_i = 1` → `data_o` shows `0x10..0x13` on 4 consecutive edges; `grant_o = 01`; `flit_cnt_o = 4`; then IDLE.
- Contention: src0 and src1 each continuously offer 3-flit packets → output order src0, src1, src0, src1. Each packet is contiguous, with one idle cycle between packets.
- Backpressure: `credit_i` low for 5 cycles mid-packet → `credit_o[g] = 0`, `data_o` stable, no transfers counted; resumes without flit loss or duplication.
- Single-flit packets: src1 alone sends 3 EOP-only flits → 3 grants, transfers at edges 1, 3 and 5 relative to the first request; `flit_cnt_o = 1` after each.
- Reset mid-packet: assert `rst_i` after flit 2 of 5 → outputs at reset values at once, `rr_ptr = 0`. After release, src0 wins a simultaneous src0/src1 request.
- Wrap with `N_SRC = 3`: after a src2 packet, src0 and src2 request together → src0 is granted.

Source files
------------

// File: rtl/inject_pkg.sv
// Shared types and constants for the NoC local-port injection arbiter.
package inject_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned FLIT_CNT_W = 16;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: one-hot grant of the first request
// at or above the pointer, searching upward and wrapping.
module rr_select #(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_SRC-1:0] gnt
);

    logic [N_SRC-1:0] req_rot;
    logic [N_SRC-1:0] gnt_rot;

    // Rotate so the pointer lands on bit 0, isolate the lowest set bit,
    // then rotate the one-hot result back into source order.
    always_comb begin
        req_rot = N_SRC'({req, req} >> ptr);
        gnt_rot = req_rot & (~req_rot + N_SRC'(1));
        gnt     = N_SRC'(({gnt_rot, gnt_rot} << ptr) >> N_SRC);
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC local injection port
// among N_SRC flit sources; the port stays locked to one source per packet.
module noc_inject_arbiter
    import inject_pkg::*;
#(
    parameter int unsigned FLIT_SIZE = 32,
    parameter int unsigned N_SRC     = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_SRC-1:0]           tx_i,
    input  logic [N_SRC-1:0]           eop_i,
    input  logic [N_SRC*FLIT_SIZE-1:0] data_i,
    output logic [N_SRC-1:0]           credit_o,
    output logic                       tx_o,
    output logic [FLIT_SIZE-1:0]       data_o,
    input  logic                       credit_i,
    output logic [N_SRC-1:0]           grant_o,
    output logic [FLIT_CNT_W-1:0]      flit_cnt_o
);

    localparam int unsigned PTR_W = $clog2(N_SRC);

    arb_state_t              state_q, state_d;
    logic [N_SRC-1:0]        grant_q, grant_d;
    logic [N_SRC-1:0]        sel_gnt;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        next_ptr;
    logic [FLIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    tx_sel;
    logic                    eop_sel;
    logic                    xfer;
    logic [FLIT_SIZE-1:0]    data_sel;

    rr_select #(
        .N_SRC (N_SRC),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req (tx_i),
        .ptr (rr_ptr_q),
        .gnt (sel_gnt)
    );

    // Granted-source mux; grant_q is zero outside LOCKED so everything folds to 0.
    always_comb begin
        tx_sel   = |(tx_i & grant_q);
        eop_sel  = |(eop_i & grant_q);
        data_sel = '0;
        next_ptr = '0;
        for (int unsigned s = 0; s < N_SRC; s++) begin
            if (grant_q[s]) begin
                data_sel = data_i[s*FLIT_SIZE +: FLIT_SIZE];
                next_ptr = (s == N_SRC - 1) ? '0 : PTR_W'(s + 1);
            end
        end
    end

    always_comb begin
        tx_o       = (state_q == LOCKED) && tx_sel;
        data_o     = tx_o ? data_sel : '0;
        credit_o   = ((state_q == LOCKED) && credit_i) ? grant_q : '0;
        grant_o    = grant_q;
        flit_cnt_o = cnt_q;
        xfer       = tx_o && credit_i;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|tx_i) begin
                    grant_d = sel_gnt;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + FLIT_CNT_W'(1);
                    end
                    if (eop_sel) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed self-checking bench for noc_inject_arbiter (N_SRC=2 plus an N_SRC=3 wrap instance).
module tb_noc_inject_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic [1:0]  tx_i, eop_i, credit_o, grant_o;
    logic [63:0] data_i;
    logic        tx_o, credit_i;
    logic [31:0] data_o;
    logic [15:0] flit_cnt_o;

    logic [2:0]  w_tx_i, w_eop_i, w_credit_o, w_grant_o;
    logic [95:0] w_data_i;
    logic        w_tx_o, w_credit_i;
    logic [31:0] w_data_o;
    logic [15:0] w_flit_cnt_o;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [31:0] sdata [2][16];
    logic        seop  [2][16];
    int          sn [2];
    int          sp [2];

    logic        o_tx;
    logic [31:0] o_data;
    logic [1:0]  o_grant, o_credit;
    logic [15:0] o_cnt;

    int          x_cyc   [$];
    logic [31:0] x_data  [$];
    logic [1:0]  x_grant [$];
    logic [15:0] x_cnt   [$];

    noc_inject_arbiter #(.FLIT_SIZE(32), .N_SRC(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .tx_i       (tx_i),
        .eop_i      (eop_i),
        .data_i     (data_i),
        .credit_o   (credit_o),
        .tx_o       (tx_o),
        .data_o     (data_o),
        .credit_i   (credit_i),
        .grant_o    (grant_o),
        .flit_cnt_o (flit_cnt_o)
    );

    noc_inject_arbiter #(.FLIT_SIZE(32), .N_SRC(3)) dut3 (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .tx_i       (w_tx_i),
        .eop_i      (w_eop_i),
        .data_i     (w_data_i),
        .credit_o   (w_credit_o),
        .tx_o       (w_tx_o),
        .data_o     (w_data_o),
        .credit_i   (w_credit_i),
        .grant_o    (w_grant_o),
        .flit_cnt_o (w_flit_cnt_o)
    );

    task automatic clear_log();
        x_cyc.delete();
        x_data.delete();
        x_grant.delete();
        x_cnt.delete();
        cyc = 0;
    endtask

    task automatic apply_reset();
        rst_i      = 1'b1;
        tx_i       = '0;
        eop_i      = '0;
        data_i     = '0;
        credit_i   = 1'b1;
        w_tx_i     = '0;
        w_eop_i    = '0;
        w_data_i   = '0;
        w_credit_i = 1'b1;
        sn = '{0, 0};
        sp = '{0, 0};
        clear_log();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic load_flit(input int s, input logic [31:0] d, input logic e);
        sdata[s][sn[s]] = d;
        seop[s][sn[s]]  = e;
        sn[s]++;
    endtask

    task automatic drive_src();
        for (int s = 0; s < 2; s++) begin
            if (sp[s] < sn[s]) begin
                tx_i[s]            = 1'b1;
                eop_i[s]           = seop[s][sp[s]];
                data_i[s*32 +: 32] = sdata[s][sp[s]];
            end else begin
                tx_i[s]            = 1'b0;
                eop_i[s]           = 1'b0;
                data_i[s*32 +: 32] = '0;
            end
        end
    endtask

    // One clock of the source model: present head flits, sample outputs at
    // the falling edge, then pop any flit credited on the rising edge.
    task automatic cycle();
        drive_src();
        @(negedge clk);
        o_tx     = tx_o;
        o_data   = data_o;
        o_grant  = grant_o;
        o_credit = credit_o;
        o_cnt    = flit_cnt_o;
        @(posedge clk);
        #1;
        if (o_tx && credit_i) begin
            x_cyc.push_back(cyc);
            x_data.push_back(o_data);
            x_grant.push_back(o_grant);
            x_cnt.push_back(flit_cnt_o);
        end
        for (int s = 0; s < 2; s++) begin
            if (o_credit[s] && tx_i[s]) sp[s]++;
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        tx_i     = 2'b11;
        eop_i    = '0;
        data_i   = {32'hDEAD_BEEF, 32'hCAFE_F00D};
        credit_i = 1'b1;
        w_tx_i = '0; w_eop_i = '0; w_data_i = '0; w_credit_i = 1'b1;
        #3;
        total++; if (tx_o !== 1'b0) $display("FAIL reset_tx_o: got %b expected 0", tx_o); else passed++;
        total++; if (data_o !== 32'h0) $display("FAIL reset_data_o: got %h expected 0", data_o); else passed++;
        total++; if (credit_o !== 2'b00) $display("FAIL reset_credit_o: got %b expected 00", credit_o); else passed++;
        total++; if (grant_o !== 2'b00) $display("FAIL reset_grant_o: got %b expected 00", grant_o); else passed++;
        total++; if (flit_cnt_o !== 16'h0) $display("FAIL reset_flit_cnt: got %0d expected 0", flit_cnt_o); else passed++;
    endtask

    task automatic test_single_source();
        apply_reset();
        for (int i = 0; i < 4; i++) load_flit(0, 32'h10 + i, i == 3);
        cycle();
        total++; if (o_tx !== 1'b0 || o_grant !== 2'b00) $display("FAIL single_idle_first: tx=%b grant=%b expected tx=0 grant=00", o_tx, o_grant); else passed++;
        for (int c = 0; c < 5; c++) cycle();
        total++; if (x_cyc.size() != 4) $display("FAIL single_count: got %0d transfers expected 4", x_cyc.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= x_cyc.size()) $display("FAIL single_flit%0d: missing expected data %h", i, 32'h10 + i);
            else if (x_data[i] !== 32'h10 + i || x_cyc[i] != i + 1 || x_grant[i] !== 2'b01)
                $display("FAIL single_flit%0d: got data=%h cyc=%0d grant=%b expected data=%h cyc=%0d grant=01",
                         i, x_data[i], x_cyc[i], x_grant[i], 32'h10 + i, i + 1);
            else passed++;
        end
        total++; if (flit_cnt_o !== 16'd4) $display("FAIL single_flit_cnt: got %0d expected 4", flit_cnt_o); else passed++;
        total++; if (grant_o !== 2'b00 || tx_o !== 1'b0) $display("FAIL single_back_idle: grant=%b tx=%b expected 00/0", grant_o, tx_o); else passed++;
    endtask

    task automatic test_contention();
        int          pkt, f, src;
        logic [31:0] exp_d;
        int          exp_c;
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                load_flit(0, 32'h100 + 32'(p * 16) + 32'(i), i == 2);
                load_flit(1, 32'h200 + 32'(p * 16) + 32'(i), i == 2);
            end
        end
        for (int c = 0; c < 18; c++) cycle();
        total++; if (x_cyc.size() != 12) $display("FAIL contention_count: got %0d transfers expected 12", x_cyc.size()); else passed++;
        // Packet order src0,src1,src0,src1; 3 flits + 1 arbitration cycle each.
        for (int i = 0; i < 12; i++) begin
            pkt   = i / 3;
            f     = i % 3;
            src   = pkt % 2;
            exp_d = (src == 0 ? 32'h100 : 32'h200) + 32'((pkt / 2) * 16) + 32'(f);
            exp_c = pkt * 4 + f + 1;
            total++;
            if (i >= x_cyc.size()) $display("FAIL contention_flit%0d: missing expected data %h", i, exp_d);
            else if (x_data[i] !== exp_d || x_cyc[i] != exp_c || x_grant[i] !== 2'(1 << src))
                $display("FAIL contention_flit%0d: got data=%h cyc=%0d grant=%b expected data=%h cyc=%0d src=%0d",
                         i, x_data[i], x_cyc[i], x_grant[i], exp_d, exp_c, src);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int exp_c [5] = '{1, 2, 8, 9, 10};
        apply_reset();
        for (int i = 0; i < 5; i++) load_flit(0, 32'h30 + i, i == 4);
        for (int c = 0; c < 13; c++) begin
            credit_i = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
            cycle();
            if (c >= 3 && c <= 7) begin
                total++;
                if (o_credit !== 2'b00 || o_tx !== 1'b1 || o_data !== 32'h32 || o_cnt !== 16'd2)
                    $display("FAIL bp_stall_c%0d: credit=%b tx=%b data=%h cnt=%0d expected 00/1/32/2",
                             c, o_credit, o_tx, o_data, o_cnt);
                else passed++;
            end
        end
        credit_i = 1'b1;
        total++; if (x_cyc.size() != 5) $display("FAIL bp_count: got %0d transfers expected 5", x_cyc.size()); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= x_cyc.size()) $display("FAIL bp_flit%0d: missing expected data %h", i, 32'h30 + i);
            else if (x_data[i] !== 32'h30 + i || x_cyc[i] != exp_c[i])
                $display("FAIL bp_flit%0d: got data=%h cyc=%0d expected data=%h cyc=%0d",
                         i, x_data[i], x_cyc[i], 32'h30 + i, exp_c[i]);
            else passed++;
        end
        total++; if (flit_cnt_o !== 16'd5) $display("FAIL bp_flit_cnt: got %0d expected 5", flit_cnt_o); else passed++;
    endtask

    task automatic test_single_flit();
        apply_reset();
        for (int i = 0; i < 3; i++) load_flit(1, 32'h40 + i, 1'b1);
        for (int c = 0; c < 7; c++) cycle();
        total++; if (x_cyc.size() != 3) $display("FAIL sflit_count: got %0d transfers expected 3", x_cyc.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= x_cyc.size()) $display("FAIL sflit_%0d: missing expected data %h", i, 32'h40 + i);
            else if (x_data[i] !== 32'h40 + i || x_cyc[i] != 2 * i + 1 || x_grant[i] !== 2'b10 || x_cnt[i] !== 16'd1)
                $display("FAIL sflit_%0d: got data=%h cyc=%0d grant=%b cnt=%0d expected data=%h cyc=%0d grant=10 cnt=1",
                         i, x_data[i], x_cyc[i], x_grant[i], x_cnt[i], 32'h40 + i, 2 * i + 1);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        load_flit(0, 32'h48, 1'b1);
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) load_flit(0, 32'h50 + i, i == 4);
        for (int c = 0; c < 3; c++) cycle();
        total++; if (x_cyc.size() != 3) $display("FAIL rmid_pre_count: got %0d transfers expected 3", x_cyc.size()); else passed++;
        #2;
        rst_i = 1'b1;
        #1;
        total++;
        if (tx_o !== 1'b0 || data_o !== 32'h0 || credit_o !== 2'b00 || grant_o !== 2'b00 || flit_cnt_o !== 16'h0)
            $display("FAIL rmid_async: tx=%b data=%h credit=%b grant=%b cnt=%0d expected all 0",
                     tx_o, data_o, credit_o, grant_o, flit_cnt_o);
        else passed++;
        sn = '{0, 0};
        sp = '{0, 0};
        tx_i = '0; eop_i = '0; data_i = '0;
        #2;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        clear_log();
        load_flit(0, 32'h70, 1'b1);
        load_flit(1, 32'h60, 1'b1);
        for (int c = 0; c < 5; c++) cycle();
        total++;
        if (x_cyc.size() != 2) $display("FAIL rmid_post_count: got %0d transfers expected 2", x_cyc.size());
        else if (x_data[0] !== 32'h70 || x_grant[0] !== 2'b01 || x_cyc[0] != 1)
            $display("FAIL rmid_src0_first: got data=%h grant=%b cyc=%0d expected 70/01/1", x_data[0], x_grant[0], x_cyc[0]);
        else passed++;
        total++;
        if (x_cyc.size() != 2) $display("FAIL rmid_src1_second: got %0d transfers expected 2", x_cyc.size());
        else if (x_data[1] !== 32'h60 || x_grant[1] !== 2'b10 || x_cyc[1] != 3)
            $display("FAIL rmid_src1_second: got data=%h grant=%b cyc=%0d expected 60/10/3", x_data[1], x_grant[1], x_cyc[1]);
        else passed++;
    endtask

    task automatic test_wrap();
        apply_reset();
        w_data_i = {32'hC2, 32'hC1, 32'hC0};
        w_tx_i   = 3'b100;
        w_eop_i  = 3'b100;
        @(negedge clk);
        total++; if (w_grant_o !== 3'b000 || w_tx_o !== 1'b0) $display("FAIL wrap_idle: grant=%b tx=%b expected 000/0", w_grant_o, w_tx_o); else passed++;
        @(negedge clk);
        total++;
        if (w_grant_o !== 3'b100 || w_tx_o !== 1'b1 || w_data_o !== 32'hC2 || w_credit_o !== 3'b100)
            $display("FAIL wrap_src2: grant=%b tx=%b data=%h credit=%b expected 100/1/c2/100", w_grant_o, w_tx_o, w_data_o, w_credit_o);
        else passed++;
        @(posedge clk);
        #1;
        w_tx_i  = 3'b101;
        w_eop_i = 3'b101;
        total++; if (w_grant_o !== 3'b000 || w_flit_cnt_o !== 16'd1) $display("FAIL wrap_after_src2: grant=%b cnt=%0d expected 000/1", w_grant_o, w_flit_cnt_o); else passed++;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (w_grant_o !== 3'b001 || w_data_o !== 32'hC0)
            $display("FAIL wrap_src0_wins: grant=%b data=%h expected 001/c0", w_grant_o, w_data_o);
        else passed++;
        @(posedge clk);
        #1;
        w_tx_i  = 3'b100;
        w_eop_i = 3'b100;
        @(negedge clk);
        @(negedge clk);
        total++; if (w_grant_o !== 3'b100) $display("FAIL wrap_src2_next: grant=%b expected 100", w_grant_o); else passed++;
        @(posedge clk);
        #1;
        w_tx_i  = '0;
        w_eop_i = '0;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_single_flit();
        test_reset_mid_packet();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
